// File: rtl/outmx_pkg.sv
// outmx_pkg: shared state encoding and default geometry for the output-matrix sequencer.
// Holds the FSM state enum plus default matrix size and border parameters.
// It also holds the interior constants derived from them.
package outmx_pkg;

    localparam int IMG_W = 50;
    localparam int IMG_H = 50;
    localparam int BORDER = 1;
    localparam int ADDR_W = 12;
    localparam logic [7:0] BORDER_VAL = 8'd127;

    localparam int NUM_DATA = IMG_W * IMG_H;
    localparam int INT_W = IMG_W - 2 * BORDER;
    localparam int INT_H = IMG_H - 2 * BORDER;
    localparam int FIRST_INT = BORDER * IMG_W + BORDER;
    localparam int ROW_SKIP = 2 * BORDER + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, RD, WAIT, TX, GAP} state_t;

endpackage

// File: rtl/outmx_int_addr.sv
// outmx_int_addr: raster address generator for the interior of the output matrix.
// Ports: clk/rst (async active-high), load (restart at first interior address),
//        step (advance one pixel), addr (current interior RAM address),
//        last (current position is the final interior pixel).
module outmx_int_addr #(
    parameter int INT_W = 48,
    parameter int INT_H = 48,
    parameter int FIRST_INT = 51,
    parameter int ROW_SKIP = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int CW = $clog2(INT_W);
    localparam int RW = $clog2(INT_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign last = (col == CW'(INT_W - 1)) && (row == RW'(INT_H - 1));

    // At the end of a row, skip the right border of this row and the left border of the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            col <= '0;
            row <= '0;
        end else if (load) begin
            addr <= ADDR_W'(FIRST_INT);
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col == CW'(INT_W - 1)) begin
                addr <= addr + ADDR_W'(ROW_SKIP);
                col <= '0;
                row <= row + 1'b1;
            end else begin
                addr <= addr + 1'b1;
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/outmx_ctrl.sv
// outmx_ctrl: per-frame sequencer for the output-matrix RAM.
// Each frame clears the matrix to BORDER_VAL and writes the pixel stream into the interior.
// It then drains every byte in raster order to the UART transmitter.
// Ports: clk/rst (async active-high), start (arm pulse, IDLE only),
//        pix_valid/pix_data/pix_ready (pixel stream in),
//        mem_addr/mem_wdata/mem_we/mem_rdata (single-port RAM, 1-cycle read),
//        tx_data/tx_start/tx_busy (UART TX handshake),
//        busy (not IDLE), frame_done (pulse after the last byte is handed off).
module outmx_ctrl #(
    parameter int IMG_W = outmx_pkg::IMG_W,
    parameter int IMG_H = outmx_pkg::IMG_H,
    parameter int BORDER = outmx_pkg::BORDER,
    parameter logic [7:0] BORDER_VAL = outmx_pkg::BORDER_VAL,
    parameter int ADDR_W = outmx_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              frame_done
);

    import outmx_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    state_t state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt, mem_addr_nxt, int_addr;
    logic [7:0] mem_wdata_nxt, tx_data_nxt;
    logic mem_we_nxt, tx_start_nxt, frame_done_nxt, pix_ready_nxt, busy_nxt;
    logic filled, filled_nxt, load, step, int_last;

    outmx_int_addr #(
        .INT_W(IMG_W - 2 * BORDER),
        .INT_H(IMG_H - 2 * BORDER),
        .FIRST_INT(BORDER * IMG_W + BORDER),
        .ROW_SKIP(2 * BORDER + 1),
        .ADDR_W(ADDR_W)
    ) u_int_addr (
        .clk(clk),
        .rst(rst),
        .load(load),
        .step(step),
        .addr(int_addr),
        .last(int_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            filled <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_we <= 1'b0;
            tx_data <= '0;
            tx_start <= 1'b0;
            frame_done <= 1'b0;
            pix_ready <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_nxt;
            addr <= addr_nxt;
            filled <= filled_nxt;
            mem_addr <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_we <= mem_we_nxt;
            tx_data <= tx_data_nxt;
            tx_start <= tx_start_nxt;
            frame_done <= frame_done_nxt;
            pix_ready <= pix_ready_nxt;
            busy <= busy_nxt;
        end
    end

    // Outputs are registered, so each branch computes what the RAM/TX see next cycle.
    // filled marks the extra FILL cycle in which the final interior write is presented,
    // so the first read address is not presented until the RD state.
    always_comb begin
        state_nxt = state;
        addr_nxt = addr;
        filled_nxt = filled;
        mem_addr_nxt = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_we_nxt = 1'b0;
        tx_data_nxt = tx_data;
        tx_start_nxt = 1'b0;
        frame_done_nxt = 1'b0;
        load = 1'b0;
        step = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = CLEAR;
                addr_nxt = '0;
                mem_addr_nxt = '0;
                mem_wdata_nxt = BORDER_VAL;
                mem_we_nxt = 1'b1;
            end
            CLEAR: if (addr == LAST_ADDR) begin
                state_nxt = FILL;
                load = 1'b1;
                filled_nxt = 1'b0;
            end else begin
                addr_nxt = addr + 1'b1;
                mem_addr_nxt = addr + 1'b1;
                mem_we_nxt = 1'b1;
            end
            FILL: if (filled) begin
                state_nxt = RD;
                addr_nxt = '0;
                mem_addr_nxt = '0;
            end else if (pix_valid && pix_ready) begin
                step = 1'b1;
                mem_we_nxt = 1'b1;
                mem_addr_nxt = int_addr;
                mem_wdata_nxt = pix_data;
                filled_nxt = int_last;
            end
            RD: state_nxt = WAIT;
            WAIT: begin
                tx_data_nxt = mem_rdata;
                state_nxt = TX;
            end
            TX: if (!tx_busy) begin
                tx_start_nxt = 1'b1;
                state_nxt = GAP;
            end
            GAP: if (addr == LAST_ADDR) begin
                frame_done_nxt = 1'b1;
                state_nxt = IDLE;
            end else begin
                addr_nxt = addr + 1'b1;
                mem_addr_nxt = addr + 1'b1;
                state_nxt = RD;
            end
            default: state_nxt = IDLE;
        endcase
        pix_ready_nxt = (state_nxt == FILL) && !filled_nxt;
        busy_nxt = state_nxt != IDLE;
    end

endmodule

// File: tb/tb_outmx_ctrl.sv
// tb_outmx_ctrl: scoreboard bench for outmx_ctrl with a RAM model and a UART TX busy model.
module tb_outmx_ctrl;

    import outmx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic pix_valid = 1'b0;
    logic [7:0] pix_data = '0;
    logic pix_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic mem_we;
    logic [7:0] mem_rdata;
    logic [7:0] tx_data;
    logic tx_start;
    logic tx_busy;
    logic busy;
    logic frame_done;

    int n_chk = 0;
    int n_fail = 0;
    int n_tx = 0;
    int n_done = 0;
    int busy_len = 10;
    int busy_cnt;

    logic [7:0] ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W+7:0] wq[$];
    logic [7:0] tq[$];

    always #5 clk = ~clk;

    outmx_ctrl dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .busy(busy),
        .frame_done(frame_done)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = busy_cnt != 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int addr_of(input int idx);
        return (idx / INT_W + BORDER) * IMG_W + (idx % INT_W) + BORDER;
    endfunction

    function automatic logic [7:0] exp_byte(input int a);
        int r = a / IMG_W;
        int c = a % IMG_W;
        if (r < BORDER || r >= IMG_H - BORDER || c < BORDER || c >= IMG_W - BORDER) return BORDER_VAL;
        return 8'((r - BORDER) * INT_W + (c - BORDER));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wq.size() == 0) chk("spurious_write", 32'(wq.size()), 1);
                else chk("write", 32'({mem_addr, mem_wdata}), 32'(wq.pop_front()));
            end
            if (tx_start) begin
                n_tx++;
                chk("tx_while_busy", 32'(tx_busy), 0);
                if (tq.size() == 0) chk("spurious_tx", 32'(tq.size()), 1);
                else chk("tx_byte", 32'(tx_data), 32'(tq.pop_front()));
            end
            if (frame_done) begin
                n_done++;
                chk("done_after_last", n_tx, NUM_DATA);
            end
        end
    end

    task automatic push_clear();
        for (int a = 0; a < NUM_DATA; a++) wq.push_back({ADDR_W'(a), BORDER_VAL});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(input int lim);
        int c = 0;
        while (!pix_ready && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk("ready_reached", 32'(pix_ready), 1);
    endtask

    task automatic send_pixels(input int n, input int duty);
        int idx = 0;
        int c = 0;
        while (idx < n && c < 20000) begin
            @(negedge clk);
            c++;
            pix_valid = ($urandom_range(99) < duty);
            pix_data = 8'(idx);
            if (pix_valid && pix_ready) begin
                wq.push_back({ADDR_W'(addr_of(idx)), pix_data});
                idx++;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        chk("pixels_sent", idx, n);
    endtask

    task automatic wait_done(input int lim, input bit poke);
        int c = 0;
        int d0 = n_done;
        while (n_done == d0 && c < lim) begin
            @(negedge clk);
            start = poke && busy && (c % 997 == 500);
            c++;
        end
        start = 1'b0;
        chk("frame_done_seen", n_done - d0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_pix_ready", 32'(pix_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        rst = 1'b0;

        // Abort mid-fill with an asynchronous reset.
        push_clear();
        pulse_start();
        wait_ready(3000);
        send_pixels(100, 100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_pix_ready", 32'(pix_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        chk("abort_mem_wdata", 32'(mem_wdata), 0);
        chk("abort_mem_we", 32'(mem_we), 0);
        chk("abort_tx_data", 32'(tx_data), 0);
        chk("abort_queue", 32'(wq.size()), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pix_valid = 1'b1;
        repeat (10) @(negedge clk);
        pix_valid = 1'b0;
        chk("idle_after_abort", 32'(busy), 0);

        // Clear only, no pixels; a second start mid-clear is ignored.
        push_clear();
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready(3000);
        repeat (20) @(negedge clk);
        chk("clear_writes_all", 32'(wq.size()), 0);
        chk("fill_waiting", 32'(pix_ready), 1);
        chk("fill_busy", 32'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Full frame, steady pixels, slow transmitter.
        busy_len = 10;
        n_tx = 0;
        for (int a = 0; a < NUM_DATA; a++) tq.push_back(exp_byte(a));
        push_clear();
        pulse_start();
        wait_ready(3000);
        send_pixels(INT_W * INT_H, 100);
        wait_done(45000, 1'b0);
        chk("frame1_tx_count", n_tx, NUM_DATA);
        chk("frame1_ram_0", 32'(ram[0]), 127);
        chk("frame1_ram_51", 32'(ram[51]), 0);
        chk("frame1_ram_98", 32'(ram[98]), 47);
        chk("frame1_ram_100", 32'(ram[100]), 127);
        chk("frame1_ram_101", 32'(ram[101]), 48);
        chk("frame1_ram_2448", 32'(ram[2448]), 255);
        chk("frame1_ram_2499", 32'(ram[2499]), 127);
        chk("frame1_tx_left", 32'(tq.size()), 0);
        @(negedge clk);
        chk("frame1_idle", 32'(busy), 0);

        // Gappy pixel stream, fast transmitter, start pokes during drain.
        busy_len = 2;
        n_tx = 0;
        for (int a = 0; a < NUM_DATA; a++) tq.push_back(exp_byte(a));
        push_clear();
        pulse_start();
        wait_ready(3000);
        send_pixels(INT_W * INT_H, 50);
        wait_done(20000, 1'b1);
        repeat (20) @(negedge clk);
        chk("frame2_tx_count", n_tx, NUM_DATA);
        chk("frame2_done_count", n_done, 2);
        chk("frame2_no_restart", 32'(wq.size()), 0);
        chk("frame2_idle", 32'(busy), 0);
        chk("frame2_ram_51", 32'(ram[51]), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/outmx_ctrl.md
Name: outmx_ctrl

Overview:
Sequencer for the 50x50 byte output-matrix RAM feeding the UART path. Per frame it clears the whole matrix to a border value and writes the 48x48 processed-pixel stream into the interior. It then drains all 2500 bytes in raster order to the UART transmitter under a start/busy handshake. It sits between the image-processing core (pixel stream), the single-port output RAM, and the UART TX.

Parameters:
IMG_W, 50, matrix width in pixels
IMG_H, 50, matrix height in pixels
BORDER, 1, border thickness on each side; interior is (IMG_W-2*BORDER) x (IMG_H-2*BORDER)
BORDER_VAL, 127, byte written to every location during clear
ADDR_W, 12, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle arm pulse, honoured only in IDLE
pix_valid  in  1  processed pixel present
pix_data  in  8  processed pixel value
pix_ready  out  1  controller accepts pixel this cycle
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  8  RAM read data, valid 1 cycle after mem_addr with mem_we=0
tx_data  out  8  byte to UART TX
tx_start  out  1  one-cycle send pulse
tx_busy  in  1  UART TX busy
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when the last byte is handed to TX

Behaviour:
- Reset, asynchronous: state IDLE; all counters 0; mem_addr, mem_wdata, tx_data = 0; mem_we, tx_start, pix_ready, frame_done, busy = 0. A reset mid-frame aborts immediately. No further mem_we or tx_start is issued.
- mem_addr, mem_wdata, mem_we, tx_data, tx_start, frame_done are registered outputs. pix_ready is registered and equals (state==FILL).
- IDLE: on start, go to CLEAR with addr=0. start in any other state is ignored.
- CLEAR: one write per cycle, mem_we=1, mem_wdata=BORDER_VAL, addr 0..IMG_W*IMG_H-1 (2499).
  - After writing 2499, go to FILL.
  - First interior addr = BORDER*IMG_W+BORDER (51). col=0, row=0.
- FILL: pixel accepted when pix_valid && pix_ready.
  - On the cycle after acceptance: mem_we=1, mem_addr=current interior addr, mem_wdata=pix_data. mem_we=0 otherwise.
  - Stalls indefinitely while pix_valid=0.
  - Address step:
    - col < 47: addr += 1.
    - col == 47: addr += 2*BORDER+1 (3), col=0, row+=1.
  - Interior addresses run 51..98, 101..148, …, 2401..2448.
  - After pixel 2304 is accepted (row 47, col 47): pix_ready drops the next cycle and the final write completes. Then go to RD with addr=0.
- RD: mem_addr=addr, mem_we=0 → WAIT.
- WAIT: capture mem_rdata into tx_data → TX.
- TX: hold while tx_busy=1. When tx_busy=0, pulse tx_start for 1 cycle → GAP.
- GAP: one cycle; tx_busy is ignored here, to cover TX busy-assert latency.
  - If addr==2499: pulse frame_done and go to IDLE.
  - Else addr += 1 and go to RD.
- Drain order is raster, address 0 first. Exactly 2500 tx_start pulses per frame.
- Arithmetic: addr is an unsigned ADDR_W counter and never exceeds IMG_W*IMG_H-1. col and row are clog2(interior) wide.
- Simultaneous events:
  - pix_valid outside FILL is ignored, and the pixel is not consumed.
  - tx_busy high in IDLE/CLEAR/FILL has no effect.
- Latency: start to first clear write = 1 cycle. Clear takes 2500 cycles.

Decomposition:
- Shared package outmx_pkg holds:
  - the state enum: IDLE, CLEAR, FILL, RD, WAIT, TX, GAP;
  - the derived constants: NUM_DATA = IMG_W*IMG_H, INT_W = IMG_W-2*BORDER, INT_H, FIRST_INT = BORDER*IMG_W+BORDER, ROW_SKIP = 2*BORDER+1.
- One natural sub-module: outmx_int_addr. It is the interior col/row/address generator, with load and step inputs and a last output. The rest stays flat.

Test Plan:
- Reset mid-FILL after 100 pixels → all outputs 0, state IDLE, no mem_we in the following 10 cycles; a new start restarts from CLEAR at addr 0.
- start, then no pixels → 2500 writes of 127 to addresses 0..2499, then pix_ready=1 with no further mem_we.
- start, then 2304 pixels with value = index mod 256 and pix_valid constant → write 0 lands at 51, write 47 at 98, write 48 at 101, last write at 2448. RAM model: border bytes = 127, interior matches the sent values.
- Random pix_valid gaps (50% duty) → identical RAM contents to the previous test; no write while pix_valid=0.
- TX model holds busy for 10 cycles per byte → 2500 tx_start pulses, never while tx_busy=1. Bytes 0..50 = 127, byte 51 = 0. frame_done fires once, in the cycle the FSM leaves GAP after the 2500th byte.
- start pulsed during drain → ignored: byte count stays 2500, and no clear writes occur until the next start from IDLE.
